// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Holds the opcode constants the hazard logic compares against and the
// controller state encoding (2'b11 is unused and is treated as RUN).
package pipeline_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BUBBLE = 7'b0000000;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StErr     = 2'b10
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard detector (combinational).
// Ports:
//   id_opcode, id_rs1, id_rs2 : decode-stage opcode and source registers
//   ex_opcode, ex_rd          : execute-stage opcode and destination register
//   load_use                  : EX holds a load whose result ID needs now
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [6:0] ex_opcode,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  // x0 never carries a dependency and a bubble in ID reads nothing.
  assign load_use = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                    (id_opcode != OP_BUBBLE) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller.
// Drives the five stage-register enables and the IF/ID, ID/EX bubble flushes
// from a RUN / MEM_WAIT / ERR state machine plus load-use and branch inputs.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   id_*, ex_*               : decode / execute stage fields for hazard detection
//   branch_taken             : EX redirect
//   mem_req, mem_ready       : data-memory handshake from MEM stage
//   *_en, *_flush            : stage register enables and bubble inserts
//   mem_err                  : sticky memory-timeout error
//   state                    : current state for debug
//   stall_cycles             : cycles with pc_en low (only with STALL_CNT_EN)
// Configuration: define STALL_CNT_EN to add the stall_cycles counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [6:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_err,
  output logic [1:0]  state
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       load_use;
  logic       run_rules;

  load_use_detect u_load_use (
    .id_opcode (id_opcode),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .ex_opcode (ex_opcode),
    .ex_rd     (ex_rd),
    .load_use  (load_use)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    run_rules   = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    case (state_q)
      StMemWait: begin
        if (mem_ready) begin
          // Exit cycle acts on any branch/load-use held during the wait.
          run_rules = 1'b1;
          state_d   = StRun;
          cnt_d     = 8'd0;
        end else if (cnt_q == TimeoutVal) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        // RUN, and the unused encoding 2'b11 which decodes as RUN.
        if (mem_req && !mem_ready) begin
          state_d = StMemWait;
          cnt_d   = 8'd1;
        end else begin
          run_rules = 1'b1;
          state_d   = StRun;
        end
      end
    endcase

    if (run_rules) begin
      if (branch_taken) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, push one bubble into ID/EX, let older stages drain.
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
        id_ex_flush = 1'b1;
      end else begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state   = state_q;
  assign mem_err = err_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 32'd0;
    end else if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum consecutive data-memory wait cycles before an error is flagged (range 1..255).
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- id_opcode  in  7  opcode in the decode stage.
- id_rs1, id_rs2  in  5 each  decode-stage source register indices.
- ex_opcode  in  7  opcode in the execute stage.
- ex_rd  in  5  execute-stage destination register index.
- branch_taken  in  1  EX-stage branch/jump resolved taken (redirect).
- mem_req  in  1  MEM stage issuing a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (opcode 7'b0000000) into that register.
- mem_err  out  1  sticky memory-timeout error.
- state  out  2  current FSM state, for debug.

Function
REQ-003 The block SHALL be a registered FSM with states RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10; 2'b11 SHALL never be entered and SHALL decode as RUN.
REQ-004 Control outputs SHALL be combinational from the current state and current inputs; only state, wait counter and mem_err SHALL be registered.
REQ-005 load_use SHALL be true iff ex_opcode==7'b0000011, ex_rd!=0, id_opcode!=7'b0000000, and ex_rd equals id_rs1 or id_rs2.
REQ-006 Priority in RUN, highest first: memory wait, branch redirect, load-use, normal.
REQ-007 RUN with mem_req=1 and mem_ready=0: all five enables 0, no flushes; next state MEM_WAIT; wait counter loaded with 1.
REQ-008 RUN with branch_taken=1, no memory wait: all enables 1, if_id_flush=1, id_ex_flush=1; next RUN.
REQ-009 RUN with load_use, no branch and no memory wait: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; exactly one bubble; next RUN.
REQ-010 RUN otherwise: all enables 1, no flushes.
REQ-011 In MEM_WAIT, all enables SHALL be 0 and no flushes SHALL be asserted, regardless of branch_taken or load_use.
REQ-012 MEM_WAIT exit on mem_ready=1: that cycle SHALL be evaluated with RUN rules REQ-008..010 (memory wait excluded); next RUN; counter cleared.
REQ-013 MEM_WAIT with mem_ready=0: counter increments, saturating at 255; when counter==MEM_TIMEOUT and mem_ready=0, next state ERR and mem_err set.
REQ-014 In ERR, all enables SHALL be 0; ERR SHALL be left only by reset; mem_ready is ignored.
REQ-015 A branch_taken held through MEM_WAIT SHALL be acted on in the exit cycle, with no redirect lost or duplicated.

Reset
REQ-016 While reset=1 at a clock edge: state<=RUN, counter<=0, mem_err<=0. This holds mid-MEM_WAIT and in ERR.
REQ-017 During the reset cycle, outputs SHALL follow the RUN decode of the current (pre-reset) registers.

Configuration
REQ-018 With STALL_CNT_EN defined: extra output stall_cycles (out, 32) SHALL count cycles with pc_en=0, saturate at 32'hFFFFFFFF, and reset to 0.
REQ-019 Without STALL_CNT_EN: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-020 A shared package SHALL hold the opcode constants OP_LOAD=7'b0000011, OP_BRANCH=7'b1100011 and OP_BUBBLE=7'b0000000, plus the state encoding typedef.
REQ-021 Load-use detection SHALL be a combinational sub-module, load_use_detect (inputs id/ex fields, output load_use).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ex_opcode=0000011, ex_rd=5, id_rs2=5, id_opcode=0110011 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1.
- Same as above but ex_rd=0 -> no stall.
- branch_taken=1 with load_use=1 -> if_id_flush=id_ex_flush=1, pc_en=1.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with branch_taken=1 -> enables 0 for 3 cycles, then a flush cycle, state RUN.
- MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 and state=ERR at the 5th edge after entry; stays until reset=1, then state RUN and mem_err=0.
- STALL_CNT_EN defined, two load-use stalls plus a 3-cycle memory wait -> stall_cycles=5.
